demux_rr_ctrl: RTL and testbench

DEMUX_RR_CTRL -- requirements
Module: demux_rr_ctrl

---
 rtl/demux_rr_ctrl.sv | 99 +++++++++
 tb/tb_demux_rr_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_ctrl.sv
// One-deep demultiplexer: holds a single upstream word and offers it to one of four
// channels, chosen round-robin over an enable mask or by a fixed two-bit select.
module demux_rr_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             s1,
  input  logic             s0,
  input  logic [3:0]       en,
  input  logic             y_valid,
  input  logic [WIDTH-1:0] y_data,
  output logic             y_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       out_ready,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q;
  logic [3:0]       outValid_q;
  logic [WIDTH-1:0] outData_q;
  logic [1:0]       ptr_q;
  logic [15:0]      xferCnt_q;

  logic       complete;
  logic       accept;
  logic       rrFound;
  logic [1:0] rrCh;
  logic [1:0] rrIdx;
  logic       chAvail;
  logic [1:0] ch_d;
  logic [1:0] ptr_d;

  assign complete = |(outValid_q & out_ready);

  // Search starts just past the last grant so every enabled channel gets a turn;
  // the pointer itself is checked last.
  always_comb begin
    rrFound = 1'b0;
    rrCh    = ptr_q;
    rrIdx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      rrIdx = 2'(ptr_q + 2'(k));
      if (!rrFound && en[rrIdx]) begin
        rrFound = 1'b1;
        rrCh    = rrIdx;
      end
    end
  end

  always_comb begin
    chAvail = 1'b1;
    ch_d    = {s1, s0};
    ptr_d   = ptr_q;
    if (!mode) begin
      chAvail = rrFound;
      ch_d    = rrCh;
      ptr_d   = rrCh;
    end
  end

  assign y_ready = !rst && chAvail && ((state_q == IDLE) || complete);
  assign accept  = y_valid && y_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      outValid_q <= 4'b0000;
      outData_q  <= '0;
      ptr_q      <= 2'd3;
      xferCnt_q  <= 16'h0000;
    end else begin
      if (accept) begin
        state_q    <= SEND;
        outData_q  <= y_data;
        outValid_q <= 4'b0001 << ch_d;
        ptr_q      <= ptr_d;
      end else if (complete) begin
        state_q    <= IDLE;
        outValid_q <= 4'b0000;
      end
      if (complete) begin
        xferCnt_q <= xferCnt_q + 16'd1;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign xfer_cnt  = xferCnt_q;

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed bench for demux_rr_ctrl: round-robin order, fixed select with backpressure,
// empty enable mask, asynchronous reset mid-transfer and transfer counter wrap.
module tb_demux_rr_ctrl;

   logic        clk;
   logic        rst;
   logic        mode;
   logic        s1;
   logic        s0;
   logic [3:0]  en;
   logic        y_valid;
   logic [7:0]  y_data;
   logic        y_ready;
   logic [3:0]  out_valid;
   logic [7:0]  out_data;
   logic [3:0]  out_ready;
   logic [15:0] xfer_cnt;

   int checkCount;
   int errorCount;

   demux_rr_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .s1        (s1),
      .s0        (s0),
      .en        (en),
      .y_valid   (y_valid),
      .y_data    (y_data),
      .y_ready   (y_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   // Free-running 10 ns clock; rising edges land at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expected value and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advances one rising edge and settles 1 ns past it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Synchronous-looking reset pulse; pointer returns to 3 so channel 0 is granted first.
   task automatic resetDut();
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      mode       = 1'b0;
      s1         = 1'b0;
      s0         = 1'b0;
      en         = 4'b1111;
      y_valid    = 1'b1;
      y_data     = 8'hEE;
      out_ready  = 4'b1111;

      // Outputs held cleared and y_ready low while reset is asserted.
      #1;
      checkOutput("reset y_ready", {31'd0, y_ready}, 32'd0);
      applyStimulus();
      checkOutput("reset out_valid", {28'd0, out_valid}, 32'h0);
      checkOutput("reset out_data", {24'd0, out_data}, 32'h0);
      checkOutput("reset xfer_cnt", {16'd0, xfer_cnt}, 32'h0);

      // Round robin over all four channels, six back-to-back words.
      rst     = 1'b0;
      y_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         y_data = 8'h10 + 8'(i);
         #1;
         checkOutput("rr4 y_ready", {31'd0, y_ready}, 32'd1);
         applyStimulus();
         checkOutput("rr4 out_valid", {28'd0, out_valid}, 32'(4'b0001 << (i % 4)));
         checkOutput("rr4 out_data", {24'd0, out_data}, 32'(8'h10 + 8'(i)));
      end
      y_valid = 1'b0;
      applyStimulus();
      checkOutput("rr4 idle out_valid", {28'd0, out_valid}, 32'h0);
      checkOutput("rr4 xfer_cnt", {16'd0, xfer_cnt}, 32'd6);

      // Sparse mask 1010 alternates between channels b and d.
      resetDut();
      en      = 4'b1010;
      y_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         y_data = 8'h20 + 8'(i);
         applyStimulus();
         checkOutput("rr2 out_valid", {28'd0, out_valid}, (i % 2 == 0) ? 32'h2 : 32'h8);
      end
      y_valid = 1'b0;
      applyStimulus();
      checkOutput("rr2 xfer_cnt", {16'd0, xfer_cnt}, 32'd4);

      // Fixed select to channel c with its consumer stalled; selects move while held.
      mode      = 1'b1;
      s1        = 1'b1;
      s0        = 1'b0;
      en        = 4'b1111;
      out_ready = 4'b1011;
      y_valid   = 1'b1;
      y_data    = 8'hA5;
      applyStimulus();
      y_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("fix hold out_valid", {28'd0, out_valid}, 32'h4);
         checkOutput("fix hold out_data", {24'd0, out_data}, 32'hA5);
         checkOutput("fix hold y_ready", {31'd0, y_ready}, 32'd0);
         s0   = ~s0;
         mode = ~mode;
         en   = 4'b0001;
         applyStimulus();
      end
      mode      = 1'b1;
      s0        = 1'b0;
      en        = 4'b1111;
      out_ready = 4'b1111;
      #1;
      checkOutput("fix release out_valid", {28'd0, out_valid}, 32'h4);
      checkOutput("fix release out_data", {24'd0, out_data}, 32'hA5);
      checkOutput("fix release y_ready", {31'd0, y_ready}, 32'd1);
      applyStimulus();
      checkOutput("fix done out_valid", {28'd0, out_valid}, 32'h0);
      checkOutput("fix done xfer_cnt", {16'd0, xfer_cnt}, 32'd5);

      // Empty enable mask blocks acceptance until channel c is enabled.
      mode    = 1'b0;
      en      = 4'b0000;
      y_valid = 1'b1;
      y_data  = 8'h77;
      #1;
      checkOutput("noen y_ready", {31'd0, y_ready}, 32'd0);
      applyStimulus();
      checkOutput("noen out_valid", {28'd0, out_valid}, 32'h0);
      en = 4'b0100;
      #1;
      checkOutput("en c y_ready", {31'd0, y_ready}, 32'd1);
      applyStimulus();
      checkOutput("en c out_valid", {28'd0, out_valid}, 32'h4);
      checkOutput("en c out_data", {24'd0, out_data}, 32'h77);
      y_valid = 1'b0;
      applyStimulus();

      // Reset pulse between edges while channel b holds a word.
      en        = 4'b0010;
      out_ready = 4'b0000;
      y_valid   = 1'b1;
      y_data    = 8'h44;
      applyStimulus();
      y_valid = 1'b0;
      en      = 4'b1111;
      checkOutput("prerst out_valid", {28'd0, out_valid}, 32'h2);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst out_valid", {28'd0, out_valid}, 32'h0);
      checkOutput("async rst xfer_cnt", {16'd0, xfer_cnt}, 32'h0);
      checkOutput("async rst out_data", {24'd0, out_data}, 32'h0);
      #1;
      rst       = 1'b0;
      out_ready = 4'b1111;
      y_valid   = 1'b1;
      y_data    = 8'h33;
      applyStimulus();
      checkOutput("postrst out_valid", {28'd0, out_valid}, 32'h1);
      checkOutput("postrst out_data", {24'd0, out_data}, 32'h33);

      // Transfer counter wraps after 65536 completions.
      resetDut();
      mode      = 1'b0;
      en        = 4'b1111;
      out_ready = 4'b1111;
      y_valid   = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         y_data = 8'(i);
         applyStimulus();
      end
      checkOutput("wrap preload xfer_cnt", {16'd0, xfer_cnt}, 32'hFFFF);
      y_valid = 1'b0;
      applyStimulus();
      checkOutput("wrap xfer_cnt", {16'd0, xfer_cnt}, 32'h0000);
      checkOutput("wrap out_valid", {28'd0, out_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
